osnt_sume_be_to_le_downsizer: RTL and testbench

//  Transmit-side gearbox for big-endian AXI4-Stream traffic. Takes wide BE beats from the core

---
 rtl/osnt_sume_be_to_le_downsizer_pkg.sv | 15 +
 rtl/osnt_sume_byte_swap.sv | 17 +
 rtl/osnt_sume_be_to_le_downsizer.sv | 125 ++++++++++++
 tb/tb_osnt_sume_be_to_le_downsizer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_sume_be_to_le_downsizer_pkg.sv
// Shared sizing helpers for the BE->LE transmit gearbox.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package osnt_sume_be_to_le_downsizer_pkg;

    localparam int DEF_S_WIDTH     = 256;
    localparam int DEF_M_WIDTH     = 64;
    localparam int DEF_TUSER_WIDTH = 128;

    // Width of the word-index counter; a ratio of 1 still gets a 1-bit counter.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/osnt_sume_byte_swap.sv
// Reverses byte order of one word: byte at the MSB end lands at bits [7:0].
// Latency: purely combinational.
// Backpressure: none, no state.
module osnt_sume_byte_swap #(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int NB = DATA_WIDTH / 8;

    for (genvar j = 0; j < NB; j++) begin : g_byte
        assign dout[8*j +: 8] = din[DATA_WIDTH-1-8*j -: 8];
    end

endmodule

// File: rtl/osnt_sume_be_to_le_downsizer.sv
// Wide big-endian AXIS beats -> narrow little-endian words; empty tail words dropped.
// Latency: beat accepted in cycle N, word 0 valid in cycle N+1; outputs combinational from buffer.
// Backpressure: one-beat buffer; input ready only when empty or the final word drains this cycle.
module osnt_sume_be_to_le_downsizer
    import osnt_sume_be_to_le_downsizer_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = DEF_S_WIDTH,
    parameter int C_M_AXIS_DATA_WIDTH  = DEF_M_WIDTH,
    parameter int C_S_AXIS_TUSER_WIDTH = DEF_TUSER_WIDTH
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TKEEP,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TKEEP,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY
);

    localparam int S     = C_S_AXIS_DATA_WIDTH;
    localparam int M     = C_M_AXIS_DATA_WIDTH;
    localparam int KW    = S / 8;
    localparam int NB    = M / 8;
    localparam int RATIO = S / M;
    localparam int IDXW  = idx_width(RATIO);

    logic [S-1:0]                    buf_data;
    logic [KW-1:0]                   buf_keep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] buf_user;
    logic                            buf_last;
    logic                            buf_valid;
    logic [IDXW-1:0]                 idx;
    logic [IDXW-1:0]                 last_idx;

    logic [IDXW-1:0] load_last_idx;
    logic [M-1:0]    word_be;
    logic [NB-1:0]   keep_be;
    logic            fire;
    logic            at_last;
    logic            drain;
    logic            load;

    assign fire    = buf_valid & M_AXIS_TREADY;
    assign at_last = (idx == last_idx);
    assign drain   = fire & at_last;

    // Reset holds the input stalled; otherwise accept into an empty or draining buffer.
    assign S_AXIS_TREADY = ARESETN & (~buf_valid | drain);
    assign load          = S_AXIS_TVALID & S_AXIS_TREADY;

    // Highest output word carrying any kept byte; non-last beats always use every word.
    always_comb begin
        load_last_idx = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (|S_AXIS_TKEEP[KW-1-NB*k -: NB]) begin
                load_last_idx = IDXW'(k);
            end
        end
        if (!S_AXIS_TLAST) begin
            load_last_idx = IDXW'(RATIO - 1);
        end
    end

    // Select the current BE word and its keep bits from the held beat.
    always_comb begin
        word_be = '0;
        keep_be = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == IDXW'(k)) begin
                word_be = buf_data[S-1-M*k -: M];
                keep_be = buf_keep[KW-1-NB*k -: NB];
            end
        end
    end

    osnt_sume_byte_swap #(
        .DATA_WIDTH (M)
    ) u_byte_swap (
        .din  (word_be),
        .dout (M_AXIS_TDATA)
    );

    // Keep bit nearest the MSB qualifies byte 0, which now sits at the LSB.
    for (genvar j = 0; j < NB; j++) begin : g_keep
        assign M_AXIS_TKEEP[j] = keep_be[NB-1-j];
    end

    assign M_AXIS_TVALID = buf_valid;
    assign M_AXIS_TLAST  = buf_last & at_last;
    assign M_AXIS_TUSER  = buf_user;

    // Buffer load, word index advance and drain; a load in the drain cycle wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            buf_data  <= '0;
            buf_keep  <= '0;
            buf_user  <= '0;
            buf_last  <= 1'b0;
            buf_valid <= 1'b0;
            idx       <= '0;
            last_idx  <= '0;
        end else if (load) begin
            buf_data  <= S_AXIS_TDATA;
            buf_keep  <= S_AXIS_TKEEP;
            buf_user  <= S_AXIS_TUSER;
            buf_last  <= S_AXIS_TLAST;
            buf_valid <= 1'b1;
            idx       <= '0;
            last_idx  <= load_last_idx;
        end else if (drain) begin
            buf_valid <= 1'b0;
            idx       <= '0;
        end else if (fire) begin
            idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_osnt_sume_be_to_le_downsizer.sv
module tb_osnt_sume_be_to_le_downsizer;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [255:0] S_AXIS_TDATA;
    logic [31:0]  S_AXIS_TKEEP;
    logic [127:0] S_AXIS_TUSER;
    logic         S_AXIS_TLAST;
    logic         S_AXIS_TVALID;
    logic         S_AXIS_TREADY;
    logic [63:0]  M_AXIS_TDATA;
    logic [7:0]   M_AXIS_TKEEP;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0]  mon_data[$];
    logic [7:0]   mon_keep[$];
    logic [127:0] mon_user[$];
    logic         mon_last[$];
    int           mon_cyc[$];

    localparam logic [127:0] USER_A = {16{8'hA5}};
    localparam logic [127:0] USER_B = {16{8'h5A}};

    osnt_sume_be_to_le_downsizer dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TUSER  (S_AXIS_TUSER),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TUSER  (M_AXIS_TUSER),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Words seen at the falling edge with valid&ready complete on the following rising edge.
    always @(negedge ACLK) begin
        if (ARESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
            mon_data.push_back(M_AXIS_TDATA);
            mon_keep.push_back(M_AXIS_TKEEP);
            mon_user.push_back(M_AXIS_TUSER);
            mon_last.push_back(M_AXIS_TLAST);
            mon_cyc.push_back(cyc);
        end
    end

    // Packet byte i has value base+i; LE word w carries packet bytes 8w..8w+7.
    function automatic logic [63:0] exp_word(input logic [7:0] base, input int w);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = base + 8'(8*w + j);
        return r;
    endfunction

    function automatic logic [7:0] exp_keep(input int len, input int w);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = (8*w + j < len);
        return r;
    endfunction

    function automatic logic [255:0] build_data(input logic [7:0] base, input int b);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[255-8*i -: 8] = base + 8'(32*b + i);
        return d;
    endfunction

    function automatic logic [31:0] build_keep(input int len, input int b);
        logic [31:0] k;
        for (int i = 0; i < 32; i++) k[31-i] = (32*b + i < len);
        return k;
    endfunction

    task automatic clear_mon();
        mon_data.delete();
        mon_keep.delete();
        mon_user.delete();
        mon_last.delete();
        mon_cyc.delete();
    endtask

    // Presents one beat and returns one step after the edge that accepted it.
    task automatic send_beat(input logic [255:0] d, input logic [31:0] k,
                             input logic [127:0] u, input logic l);
        int c = 0;
        bit accepted = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TKEEP  = k;
        S_AXIS_TUSER  = u;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        while (!accepted && c < 100) begin
            @(negedge ACLK);
            if (S_AXIS_TREADY) accepted = 1;
            @(posedge ACLK);
            #1;
            c++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL send_beat timeout: tready never high in %0d cycles", c);
        end
    endtask

    task automatic send_packet(input logic [7:0] base, input int len, input logic [127:0] u);
        int nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++)
            send_beat(build_data(base, b), build_keep(len, b), u, b == nb - 1);
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int c = 0;
        while (mon_data.size() < n && c < 200) begin
            @(posedge ACLK);
            c++;
        end
        repeat (6) @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_ready: mvalid=%b sready=%b need 0 0", M_AXIS_TVALID, S_AXIS_TREADY);
        end
        checks++;
        if (M_AXIS_TDATA !== 64'h0 || M_AXIS_TKEEP !== 8'h0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TUSER !== 128'h0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h keep=%h last=%b user=%h need zeros",
                     M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        checks++;
        if (S_AXIS_TREADY !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: sready=%b mvalid=%b need 1 0", S_AXIS_TREADY, M_AXIS_TVALID);
        end
    endtask

    task automatic test_full_packet();
        M_AXIS_TREADY = 1'b1;
        clear_mon();
        send_packet(8'h00, 64, USER_A);
        wait_words(8);
        checks++;
        if (mon_data.size() != 8) begin
            errors++;
            $display("FAIL full_count: got %0d words need 8", mon_data.size());
        end else begin
            checks++;
            if (mon_data[0] !== 64'h0706050403020100 || mon_keep[0] !== 8'hFF) begin
                errors++;
                $display("FAIL full_word0: data=%h keep=%h need 0706050403020100 ff", mon_data[0], mon_keep[0]);
            end
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (mon_data[w] !== exp_word(8'h00, w) || mon_keep[w] !== 8'hFF || mon_last[w] !== (w == 7)) begin
                    errors++;
                    $display("FAIL full_word%0d: data=%h keep=%h last=%b need %h ff %b",
                             w, mon_data[w], mon_keep[w], mon_last[w], exp_word(8'h00, w), w == 7);
                end
            end
        end
    endtask

    task automatic test_short_tail();
        M_AXIS_TREADY = 1'b1;
        clear_mon();
        send_packet(8'h00, 70, USER_A);
        wait_words(9);
        checks++;
        if (mon_data.size() != 9) begin
            errors++;
            $display("FAIL tail_count: got %0d words need 9", mon_data.size());
        end else begin
            for (int w = 0; w < 9; w++) begin
                checks++;
                if (mon_data[w] !== exp_word(8'h00, w) || mon_keep[w] !== exp_keep(70, w) || mon_last[w] !== (w == 8)) begin
                    errors++;
                    $display("FAIL tail_word%0d: data=%h keep=%h last=%b need %h %h %b",
                             w, mon_data[w], mon_keep[w], mon_last[w], exp_word(8'h00, w), exp_keep(70, w), w == 8);
                end
            end
            checks++;
            if (mon_keep[8] !== 8'h3F || mon_last[8] !== 1'b1) begin
                errors++;
                $display("FAIL tail_word8_literal: keep=%h last=%b need 3f 1", mon_keep[8], mon_last[8]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int   exp_idx [6] = '{0, 1, 2, 2, 2, 3};
        clear_mon();
        M_AXIS_TREADY = 1'b0;
        send_beat(build_data(8'h20, 0), 32'hFFFF_FFFF, USER_B, 1'b1);
        S_AXIS_TVALID = 1'b0;
        for (int c = 0; c < 6; c++) begin
            M_AXIS_TREADY = pat[c];
            @(negedge ACLK);
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== exp_word(8'h20, exp_idx[c]) ||
                M_AXIS_TKEEP !== 8'hFF || M_AXIS_TLAST !== (exp_idx[c] == 3) ||
                S_AXIS_TREADY !== (exp_idx[c] == 3 && pat[c])) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b data=%h keep=%h last=%b sready=%b need 1 %h ff %b %b",
                         c, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, S_AXIS_TREADY,
                         exp_word(8'h20, exp_idx[c]), exp_idx[c] == 3, exp_idx[c] == 3 && pat[c]);
            end
            @(posedge ACLK);
            #1;
        end
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || mon_data.size() != 4) begin
            errors++;
            $display("FAIL bp_drain: valid=%b words=%0d need 0 4", M_AXIS_TVALID, mon_data.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (mon_data[w] !== exp_word(8'h20, w)) begin
                    errors++;
                    $display("FAIL bp_word%0d: data=%h need %h", w, mon_data[w], exp_word(8'h20, w));
                end
            end
        end
        M_AXIS_TREADY = 1'b1;
    endtask

    task automatic test_back_to_back();
        M_AXIS_TREADY = 1'b1;
        clear_mon();
        send_beat(build_data(8'h00, 0), 32'hFFFF_FFFF, USER_A, 1'b1);
        send_beat(build_data(8'h80, 0), 32'hFFFF_FFFF, USER_B, 1'b1);
        S_AXIS_TVALID = 1'b0;
        wait_words(8);
        checks++;
        if (mon_data.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d words need 8", mon_data.size());
        end else begin
            for (int w = 0; w < 8; w++) begin
                checks++;
                if (mon_cyc[w] != mon_cyc[0] + w ||
                    mon_user[w] !== ((w < 4) ? USER_A : USER_B) ||
                    mon_last[w] !== (w == 3 || w == 7) ||
                    mon_data[w] !== ((w < 4) ? exp_word(8'h00, w) : exp_word(8'h80, w - 4))) begin
                    errors++;
                    $display("FAIL b2b_word%0d: cycle_offset=%0d user=%h last=%b data=%h need offset %0d",
                             w, mon_cyc[w] - mon_cyc[0], mon_user[w], mon_last[w], mon_data[w], w);
                end
            end
        end
    endtask

    task automatic test_degenerate();
        M_AXIS_TREADY = 1'b1;
        clear_mon();
        send_beat(build_data(8'h80, 0), 32'h0, USER_A, 1'b1);
        S_AXIS_TVALID = 1'b0;
        wait_words(1);
        checks++;
        if (mon_data.size() != 1) begin
            errors++;
            $display("FAIL degen_count: got %0d words need 1", mon_data.size());
        end else begin
            checks++;
            if (mon_keep[0] !== 8'h00 || mon_last[0] !== 1'b1 || mon_data[0] !== 64'h8786858483828180) begin
                errors++;
                $display("FAIL degen_word: keep=%h last=%b data=%h need 00 1 8786858483828180",
                         mon_keep[0], mon_last[0], mon_data[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        M_AXIS_TREADY = 1'b0;
        clear_mon();
        send_beat(build_data(8'h00, 0), 32'hFFFF_FFFF, USER_A, 1'b0);
        S_AXIS_TVALID = 1'b0;
        @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b0 || M_AXIS_TDATA !== 64'h0) begin
            errors++;
            $display("FAIL areset_immediate: mvalid=%b sready=%b data=%h need 0 0 0",
                     M_AXIS_TVALID, S_AXIS_TREADY, M_AXIS_TDATA);
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL areset_no_flush: mvalid=%b need 0", M_AXIS_TVALID);
        end
        M_AXIS_TREADY = 1'b1;
        clear_mon();
        send_packet(8'h40, 16, USER_B);
        wait_words(2);
        checks++;
        if (mon_data.size() != 2) begin
            errors++;
            $display("FAIL areset_count: got %0d words need 2", mon_data.size());
        end else begin
            checks++;
            if (mon_data[0] !== 64'h4746454443424140 || mon_last[1] !== 1'b1 || mon_keep[1] !== 8'hFF) begin
                errors++;
                $display("FAIL areset_new_pkt: word0=%h last1=%b keep1=%h need 4746454443424140 1 ff",
                         mon_data[0], mon_last[1], mon_keep[1]);
            end
        end
    endtask

    initial begin
        ARESETN       = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b0;
        test_reset();
        @(posedge ACLK); #1;
        test_full_packet();
        @(posedge ACLK); #1;
        test_short_tail();
        @(posedge ACLK); #1;
        test_backpressure();
        @(posedge ACLK); #1;
        test_back_to_back();
        @(posedge ACLK); #1;
        test_degenerate();
        @(posedge ACLK); #1;
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
